sha_round_sequencer: RTL and testbench

Control and message-schedule engine for the SHA-256 round datapath. Accepts 512-bit message blocks as sixteen 32-bit words and initialises the datapath working registers A..H from the chaining value. Sequences the 64 compression rounds by driving round number, K-select and W_t on the fly, reads back the final A..H and adds it to the chaining value. Emits the 8-word digest. Sits between the host/stream interface and the round datapath, driving all of the datapath's control inputs and consuming its result output.

---
 rtl/sha256_pkg.sv | 54 +++++
 rtl/sha_msg_schedule.sv | 44 ++++
 rtl/sha_round_sequencer.sv | 174 +++++++++++++++++
 tb/tb_sha_round_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// ============================================================================
// sha256_pkg : shared constants, state encoding and message-schedule sigmas
// Revision   : 1.0
// ============================================================================
`default_nettype none

package sha256_pkg;

  localparam logic [3:0] LOAD_A  = 4'd0;
  localparam logic [3:0] LOAD_B  = 4'd1;
  localparam logic [3:0] LOAD_C  = 4'd2;
  localparam logic [3:0] LOAD_D  = 4'd3;
  localparam logic [3:0] LOAD_E  = 4'd4;
  localparam logic [3:0] LOAD_F  = 4'd5;
  localparam logic [3:0] LOAD_G  = 4'd6;
  localparam logic [3:0] LOAD_H  = 4'd7;
  localparam logic [3:0] LOAD_FB = 4'd8;
  localparam logic [3:0] HOLD    = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_INIT  = 3'd2,
    ST_ROUND = 3'd3,
    ST_READ  = 3'd4,
    ST_OUT   = 3'd5
  } state_e;

  function automatic logic [31:0] iv_word(input logic [2:0] idx);
    logic [31:0] v;
    case (idx)
      3'd0:    v = 32'h6a09e667;
      3'd1:    v = 32'hbb67ae85;
      3'd2:    v = 32'h3c6ef372;
      3'd3:    v = 32'ha54ff53a;
      3'd4:    v = 32'h510e527f;
      3'd5:    v = 32'h9b05688c;
      3'd6:    v = 32'h1f83d9ab;
      default: v = 32'h5be0cd19;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha_msg_schedule.sv
// ============================================================================
// sha_msg_schedule : 16-word sliding window producing W_t for SHA-256
// Revision         : 1.0
// ============================================================================
`default_nettype none

module sha_msg_schedule
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        adv_i,
  output logic [31:0] w_o
);

  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [31:0] w_new;

  // Entry 0 always holds W_t; entry k holds W_{t+k}.
  assign w_o   = win_q[0];
  assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_comb begin
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
    if (load_i || adv_i) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = load_i ? word_i : w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/sha_round_sequencer.sv
// ============================================================================
// sha_round_sequencer : block intake, 64-round control and digest chaining
// Revision            : 1.0
// ============================================================================
`default_nettype none

module sha_round_sequencer
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] msg_word,
  input  logic        msg_valid,
  input  logic        msg_new,
  output logic        msg_ready,
  output logic [31:0] dig_word,
  output logic [2:0]  dig_idx,
  output logic        dig_valid,
  input  logic        dig_ready,
  output logic        busy,
  output logic [31:0] dp_var,
  output logic [31:0] dp_w,
  output logic [5:0]  dp_k_num,
  output logic [3:0]  dp_in_addr,
  output logic [3:0]  dp_out_addr,
  output logic        dp_en_out,
  input  logic [31:0] dp_result
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [31:0] h_q [8];
  logic [31:0] h_d [8];
  logic        sched_load;
  logic        sched_adv;
  logic [31:0] sched_w;

  sha_msg_schedule u_sched (
    .clk    (clk),
    .rst    (rst),
    .load_i (sched_load),
    .word_i (msg_word),
    .adv_i  (sched_adv),
    .w_o    (sched_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      for (int i = 0; i < 8; i++) h_q[i] <= iv_word(3'(i));
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      for (int i = 0; i < 8; i++) h_q[i] <= h_d[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    for (int i = 0; i < 8; i++) h_d[i] = h_q[i];
    msg_ready   = 1'b0;
    busy        = 1'b1;
    dig_valid   = 1'b0;
    dig_word    = '0;
    dig_idx     = '0;
    dp_var      = '0;
    dp_w        = '0;
    dp_k_num    = '0;
    dp_in_addr  = HOLD;
    dp_out_addr = '0;
    dp_en_out   = 1'b0;
    sched_load  = 1'b0;
    sched_adv   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        msg_ready = 1'b1;
        if (msg_valid) begin
          sched_load = 1'b1;
          // A new message restarts chaining from the IV.
          if (msg_new) begin
            for (int i = 0; i < 8; i++) h_d[i] = iv_word(3'(i));
          end
          cnt_d   = 6'd1;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          sched_load = 1'b1;
          if (cnt_q == 6'd15) begin
            cnt_d   = '0;
            state_d = ST_INIT;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      ST_INIT: begin
        dp_in_addr = cnt_q[3:0];
        dp_var     = h_q[cnt_q[2:0]];
        if (cnt_q == 6'd7) begin
          cnt_d   = '0;
          phase_d = 1'b0;
          state_d = ST_ROUND;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      ST_ROUND: begin
        dp_k_num = cnt_q;
        dp_w     = sched_w;
        if (!phase_q) begin
          dp_en_out = 1'b1;
          phase_d   = 1'b1;
        end else begin
          dp_in_addr = LOAD_FB;
          sched_adv  = 1'b1;
          phase_d    = 1'b0;
          if (cnt_q == 6'd63) begin
            cnt_d   = '0;
            state_d = ST_READ;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      ST_READ: begin
        dp_out_addr        = {1'b0, cnt_q[2:0]};
        h_d[cnt_q[2:0]]    = h_q[cnt_q[2:0]] + dp_result;
        if (cnt_q == 6'd7) begin
          cnt_d   = '0;
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      ST_OUT: begin
        dig_valid = 1'b1;
        dig_word  = h_q[cnt_q[2:0]];
        dig_idx   = cnt_q[2:0];
        if (dig_ready) begin
          if (cnt_q == 6'd7) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sha_round_sequencer.sv
// ============================================================================
// tb_sha_round_sequencer : directed SHA-256 vectors with a behavioural datapath
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_sha_round_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] msg_word;
  logic        msg_valid;
  logic        msg_new;
  logic        msg_ready;
  logic [31:0] dig_word;
  logic [2:0]  dig_idx;
  logic        dig_valid;
  logic        dig_ready;
  logic        busy;
  logic [31:0] dp_var;
  logic [31:0] dp_w;
  logic [5:0]  dp_k_num;
  logic [3:0]  dp_in_addr;
  logic [3:0]  dp_out_addr;
  logic        dp_en_out;
  logic [31:0] dp_result;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int e0       = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha_round_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .msg_word    (msg_word),
    .msg_valid   (msg_valid),
    .msg_new     (msg_new),
    .msg_ready   (msg_ready),
    .dig_word    (dig_word),
    .dig_idx     (dig_idx),
    .dig_valid   (dig_valid),
    .dig_ready   (dig_ready),
    .busy        (busy),
    .dp_var      (dp_var),
    .dp_w        (dp_w),
    .dp_k_num    (dp_k_num),
    .dp_in_addr  (dp_in_addr),
    .dp_out_addr (dp_out_addr),
    .dp_en_out   (dp_en_out),
    .dp_result   (dp_result)
  );

  logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic [31:0] IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic [31:0] DIG_ABC [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  logic [31:0] DIG_TWO [8] = '{32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                               32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

  logic [31:0] BLK_ABC [16] = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
  logic [31:0] BLK_2A [16] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  logic [31:0] BLK_2B [16] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                               32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};

  logic [31:0] cur_blk [16];
  logic [31:0] cur_dig [8];

  // Behavioural round datapath: working regs, capture buffer, buffer read mux.
  logic [31:0] dm [8];
  logic [31:0] bf [8];

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] rnd_t1(input logic [31:0] e, f, g, h, k, w);
    return h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
  endfunction

  function automatic logic [31:0] rnd_t2(input logic [31:0] a, b, c);
    return (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
  endfunction

  always @(posedge clk) begin
    if (dp_en_out) begin
      bf[0] <= rnd_t1(dm[4], dm[5], dm[6], dm[7], K[dp_k_num], dp_w) + rnd_t2(dm[0], dm[1], dm[2]);
      bf[1] <= dm[0];
      bf[2] <= dm[1];
      bf[3] <= dm[2];
      bf[4] <= dm[3] + rnd_t1(dm[4], dm[5], dm[6], dm[7], K[dp_k_num], dp_w);
      bf[5] <= dm[4];
      bf[6] <= dm[5];
      bf[7] <= dm[6];
    end
    if (dp_in_addr < 4'd8) dm[dp_in_addr[2:0]] <= dp_var;
    else if (dp_in_addr == 4'd8) for (int i = 0; i < 8; i++) dm[i] <= bf[i];
  end

  assign dp_result = bf[dp_out_addr[2:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic send_block(input bit new0, input bit gap);
    int to;
    for (int i = 0; i < 16; i++) begin
      if (gap) begin
        msg_valid = 1'b0;
        @(negedge clk);
      end
      msg_word  = cur_blk[i];
      msg_new   = (i == 0) ? new0 : ~new0;
      msg_valid = 1'b1;
      to = 0;
      while (!msg_ready && to < 1000) begin
        @(negedge clk);
        to++;
      end
      if (to >= 1000) begin
        check_eq("send_timeout", 32'd0, 32'd1);
        msg_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    e0        = cyc;
    msg_valid = 1'b0;
    msg_new   = 1'b0;
  endtask

  task automatic collect(input bit chk_words, input int stall_k, input int stall_len, input bit chk_lat);
    int to;
    to = 0;
    @(negedge clk);
    while (!dig_valid && to < 400) begin
      @(negedge clk);
      to++;
    end
    if (to >= 400) begin
      check_eq("digest_timeout", 32'd0, 32'd1);
      return;
    end
    if (chk_lat) check_eq("first_valid_latency", 32'(cyc - e0), 32'd144);
    for (int k = 0; k < 8; k++) begin
      if (chk_words) begin
        check_eq($sformatf("dig_valid[%0d]", k), {31'd0, dig_valid}, 32'd1);
        check_eq($sformatf("dig_idx[%0d]", k), {29'd0, dig_idx}, 32'(k));
        check_eq($sformatf("dig_word[%0d]", k), dig_word, cur_dig[k]);
      end
      if (k == stall_k) begin
        dig_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check_eq($sformatf("stall_idx[%0d]", s), {29'd0, dig_idx}, 32'(k));
          check_eq($sformatf("stall_word[%0d]", s), dig_word, cur_dig[k]);
        end
        dig_ready = 1'b1;
      end
      @(negedge clk);
    end
    check_eq("post_dig_msg_ready", {31'd0, msg_ready}, 32'd1);
    check_eq("post_dig_valid", {31'd0, dig_valid}, 32'd0);
    check_eq("post_dig_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    msg_word  = '0;
    msg_valid = 1'b0;
    msg_new   = 1'b0;
    dig_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_msg_ready", {31'd0, msg_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_dig_valid", {31'd0, dig_valid}, 32'd0);
    check_eq("rst_dig_word", dig_word, 32'd0);
    check_eq("rst_dp_in_addr", {28'd0, dp_in_addr}, 32'd15);
    check_eq("rst_dp_en_out", {31'd0, dp_en_out}, 32'd0);
    rst = 1'b0;

    // Block 1: "abc", with INIT/ROUND drive checks and a stray msg_valid mid-round.
    cur_blk = BLK_ABC;
    cur_dig = DIG_ABC;
    send_block(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("init_addr[%0d]", i), {28'd0, dp_in_addr}, 32'(i));
      check_eq($sformatf("init_var[%0d]", i), dp_var, IV[i]);
    end
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      if (c == 20) begin
        msg_valid = 1'b1;
        msg_word  = 32'hdeadbeef;
      end
      if (c == 24) msg_valid = 1'b0;
      check_eq($sformatf("k_num[%0d]", c), {26'd0, dp_k_num}, 32'(c / 2));
      check_eq($sformatf("in_addr[%0d]", c), {28'd0, dp_in_addr}, (c % 2 == 1) ? 32'd8 : 32'd15);
      check_eq($sformatf("en_out[%0d]", c), {31'd0, dp_en_out}, (c % 2 == 0) ? 32'd1 : 32'd0);
      if (c >= 20 && c < 24) check_eq("round_msg_ready", {31'd0, msg_ready}, 32'd0);
    end
    collect(1'b1, -1, 0, 1'b1);

    // Two-block message with chaining; block 2 has msg_new high only on words 1..15.
    cur_blk = BLK_2A;
    send_block(1'b1, 1'b0);
    collect(1'b0, -1, 0, 1'b0);
    cur_blk = BLK_2B;
    cur_dig = DIG_TWO;
    send_block(1'b0, 1'b0);
    collect(1'b1, -1, 0, 1'b1);

    // Fresh "abc" right after: no chaining leak.
    cur_blk = BLK_ABC;
    cur_dig = DIG_ABC;
    send_block(1'b1, 1'b0);
    collect(1'b1, -1, 0, 1'b1);

    // Gapped input and a 5-cycle consumer stall on word 3.
    send_block(1'b1, 1'b1);
    collect(1'b1, 3, 5, 1'b1);

    // Reset during round 30, then a clean block.
    send_block(1'b1, 1'b0);
    repeat (69) @(negedge clk);
    check_eq("pre_rst_k_num", {26'd0, dp_k_num}, 32'd30);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_msg_ready", {31'd0, msg_ready}, 32'd1);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_dig_valid", {31'd0, dig_valid}, 32'd0);
    check_eq("midrst_dp_in_addr", {28'd0, dp_in_addr}, 32'd15);
    check_eq("midrst_dp_k_num", {26'd0, dp_k_num}, 32'd0);
    rst = 1'b0;
    send_block(1'b1, 1'b0);
    collect(1'b1, -1, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
